spi_reg_access_ctrl: RTL and testbench
======================================

Name: spi_reg_access_ctrl

Overview:
- Command/transaction controller that sits between the SPI slave byte interface and a register bank, inside the SPI clock domain.
- Decodes a command byte (R/W + address), then sequences burst writes and prefetched burst reads with address auto-increment.
- Supplies the next byte to shift out and counts rejected commands.
- Runs only while the SPI clock toggles; CS deassertion aborts any transaction.

Parameters:
- ADDR_WIDTH, 7, register address width; command byte bits [6:0] carry the address.
- NUM_REGS, 96, number of implemented registers; valid addresses are 0..NUM_REGS-1 (NUM_REGS <= 2**ADDR_WIDTH).
- AUTO_INC, 1, 1 = address increments per data byte; 0 = address fixed for the whole burst.
- ACK_BYTE, 8'hA5, byte loaded for MISO after an accepted write command.
- ERR_BYTE, 8'hEE, byte loaded for MISO after a rejected command.

Ports:
- w_SPI_Clk  in  1  mode-adjusted SPI clock; all logic on its rising edge.
- i_Rst_L  in  1  reset, asynchronous, active-low.
- i_SPI_CS_n  in  1  chip select; high = asynchronous transaction abort.
- i_RX_Byte_Valid  in  1  one-cycle pulse; i_RX_Byte complete.
- i_RX_Byte  in  8  received byte, valid with pulse.
- o_TX_Byte  out  8  next byte for the slave to serialize.
- o_TX_Load  out  1  one-cycle pulse; o_TX_Byte updated.
- o_Reg_Addr  out  ADDR_WIDTH  register bank address.
- o_Reg_Wr_En  out  1  one-cycle write strobe.
- o_Reg_Wr_Data  out  8  write data.
- o_Reg_Rd_En  out  1  one-cycle read strobe.
- i_Reg_Rd_Data  in  8  combinational read data for o_Reg_Addr.
- o_Busy  out  1  high when state != IDLE.
- o_Err_Count  out  8  saturating count of rejected commands.

Behaviour:
- Reset (i_Rst_L low): state = IDLE; all outputs 0; internal address and prefetch registers 0.
- CS abort (i_SPI_CS_n high, asynchronous):
  - state = IDLE; o_Reg_Wr_En, o_Reg_Rd_En and o_TX_Load = 0.
  - o_Reg_Addr, o_TX_Byte and o_Err_Count hold their values.
- States: IDLE, RD_TURN, RD_DATA, WR_DATA, DROP.
- IDLE, on valid: treat the byte as the command (bit7 = 1 read, 0 write; addr = bits[6:0]).
  - addr >= NUM_REGS: go to DROP; o_TX_Byte <= ERR_BYTE; o_TX_Load pulse; o_Err_Count += 1, saturating at 255.
  - Accepted write: go to WR_DATA; r_Addr <= addr; o_TX_Byte <= ACK_BYTE; o_TX_Load pulse.
  - Accepted read: go to RD_TURN; o_Reg_Addr <= addr; o_Reg_Rd_En pulse on the next edge; r_Addr <= next(addr).
- Prefetch: on every edge where o_Reg_Rd_En = 1, r_Prefetch <= i_Reg_Rd_Data.
  - Read latency is therefore 2 edges after the command byte, well inside the 8 edges of a byte slot.
- RD_TURN, on valid (dummy byte from the master):
  - o_TX_Byte <= r_Prefetch; o_TX_Load pulse.
  - o_Reg_Addr <= r_Addr; o_Reg_Rd_En pulse; r_Addr <= next(r_Addr); go to RD_DATA.
- RD_DATA, on each valid: same actions as RD_TURN. Received bytes are ignored.
- WR_DATA, on each valid: o_Reg_Addr <= r_Addr; o_Reg_Wr_Data <= i_RX_Byte; o_Reg_Wr_En pulse; r_Addr <= next(r_Addr).
- DROP: ignore all bytes; no strobes; o_TX_Byte stays ERR_BYTE; exit only via CS abort or reset.
- next(a):
  - AUTO_INC = 0: a.
  - a = NUM_REGS-1: 0 (wrap).
  - Otherwise: a+1, computed at ADDR_WIDTH width.
- Strobe rules: o_Reg_Wr_En and o_Reg_Rd_En are never both high. Every strobe is exactly one cycle.
- Read side effect: a read burst fetches one register beyond the last byte clocked out. Registers with read side effects must tolerate this.
- A valid pulse arriving while the controller is busy cannot occur (bytes are >= 8 edges apart); no queueing is required.

Test Plan:
- Write burst: cmd 8'h05, data 11,22,33 -> Wr_En pulses at addr 5,6,7 with data 11,22,33; TX_Byte = A5 after cmd; Err_Count = 0.
- Read burst: regs 10..12 = 0xC1,0xC2,0xC3; cmd 8'h8A, dummy, 3 bytes -> TX_Load values C1,C2,C3 in order; Rd_En at 10,11,12,13.
- Bad address: cmd 8'h7F (NUM_REGS = 96) -> TX_Byte = EE; no strobes for 4 following bytes; Err_Count = 1. Repeat 300 times -> Err_Count saturates at 255.
- Wrap: write cmd to addr 95, 3 data bytes -> writes at 95,0,1. With AUTO_INC = 0 -> writes at 95,95,95.
- CS abort mid-write after 1 data byte, then new read cmd 8'h82 -> only one write occurs; read starts cleanly at addr 2; o_Busy = 0 while CS high.
- i_Rst_L low during RD_DATA -> all outputs 0 immediately; next command decodes from IDLE.

Source files
------------

// File: rtl/spi_reg_access_ctrl_if.sv
// Byte-level handshake between the SPI slave shifter, this controller
// and the register bank. The controller takes the slave modport.
interface spi_reg_access_ctrl_if #(
    parameter int ADDR_WIDTH = 7
);
    logic                  i_SPI_CS_n;
    logic                  i_RX_Byte_Valid;
    logic [7:0]            i_RX_Byte;
    logic [7:0]            o_TX_Byte;
    logic                  o_TX_Load;
    logic [ADDR_WIDTH-1:0] o_Reg_Addr;
    logic                  o_Reg_Wr_En;
    logic [7:0]            o_Reg_Wr_Data;
    logic                  o_Reg_Rd_En;
    logic [7:0]            i_Reg_Rd_Data;
    logic                  o_Busy;
    logic [7:0]            o_Err_Count;

    modport slave (
        input  i_SPI_CS_n, i_RX_Byte_Valid, i_RX_Byte, i_Reg_Rd_Data,
        output o_TX_Byte, o_TX_Load, o_Reg_Addr, o_Reg_Wr_En, o_Reg_Wr_Data,
               o_Reg_Rd_En, o_Busy, o_Err_Count
    );

    modport master (
        output i_SPI_CS_n, i_RX_Byte_Valid, i_RX_Byte, i_Reg_Rd_Data,
        input  o_TX_Byte, o_TX_Load, o_Reg_Addr, o_Reg_Wr_En, o_Reg_Wr_Data,
               o_Reg_Rd_En, o_Busy, o_Err_Count
    );
endinterface

// File: rtl/spi_reg_access_ctrl.sv
// SPI register access controller: decodes a command byte, then runs a
// burst write or a prefetched burst read with address auto-increment.
// Chip-select high aborts the transaction but keeps address/TX/error state.
module spi_reg_access_ctrl #(
    parameter int         ADDR_WIDTH = 7,
    parameter int         NUM_REGS   = 96,
    parameter bit         AUTO_INC   = 1'b1,
    parameter logic [7:0] ACK_BYTE   = 8'hA5,
    parameter logic [7:0] ERR_BYTE   = 8'hEE
) (
    input  logic                 w_SPI_Clk,
    input  logic                 i_Rst_L,
    spi_reg_access_ctrl_if.slave bus
);

    typedef enum logic [2:0] {IDLE, RD_TURN, RD_DATA, WR_DATA, DROP} state_t;

    state_t                state_q, state_d;
    logic                  wr_en_q, wr_en_d;
    logic                  rd_en_q, rd_en_d;
    logic                  tx_load_q, tx_load_d;
    logic [7:0]            tx_byte_q, tx_byte_d;
    logic [7:0]            wr_data_q, wr_data_d;
    logic [7:0]            err_cnt_q, err_cnt_d;
    logic [7:0]            pref_q, pref_d;
    logic [ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    logic                  rx_vld;
    logic                  cmd_rd;
    logic                  cmd_bad;
    logic [ADDR_WIDTH-1:0] cmd_addr;

    assign rx_vld   = bus.i_RX_Byte_Valid;
    assign cmd_rd   = bus.i_RX_Byte[7];
    assign cmd_bad  = 32'(bus.i_RX_Byte[6:0]) >= NUM_REGS;
    assign cmd_addr = ADDR_WIDTH'(bus.i_RX_Byte[6:0]);

    // Burst address step; wraps at the last implemented register.
    function automatic logic [ADDR_WIDTH-1:0] nxt(input logic [ADDR_WIDTH-1:0] a);
        if (!AUTO_INC)                       return a;
        if (a == ADDR_WIDTH'(NUM_REGS - 1)) return '0;
        return a + ADDR_WIDTH'(1);
    endfunction

    // Control state and strobes: cleared by reset, and by CS high as an abort.
    always_ff @(posedge w_SPI_Clk or negedge i_Rst_L or posedge bus.i_SPI_CS_n) begin
        if (!i_Rst_L || bus.i_SPI_CS_n) begin
            state_q   <= IDLE;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            tx_load_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            tx_load_q <= tx_load_d;
        end
    end

    // Datapath registers survive a CS abort; only reset clears them.
    always_ff @(posedge w_SPI_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            tx_byte_q  <= '0;
            wr_data_q  <= '0;
            err_cnt_q  <= '0;
            pref_q     <= '0;
            reg_addr_q <= '0;
            addr_q     <= '0;
        end else begin
            tx_byte_q  <= tx_byte_d;
            wr_data_q  <= wr_data_d;
            err_cnt_q  <= err_cnt_d;
            pref_q     <= pref_d;
            reg_addr_q <= reg_addr_d;
            addr_q     <= addr_d;
        end
    end

    // Next state: command decode from IDLE, dummy byte moves RD_TURN on.
    always_comb begin
        state_d = state_q;
        if (rx_vld) begin
            case (state_q)
                IDLE:    state_d = cmd_bad ? DROP : (cmd_rd ? RD_TURN : WR_DATA);
                RD_TURN: state_d = RD_DATA;
                default: state_d = state_q;
            endcase
        end
    end

    // Per-byte actions; read data is captured the edge after each read strobe.
    always_comb begin
        wr_en_d    = 1'b0;
        rd_en_d    = 1'b0;
        tx_load_d  = 1'b0;
        tx_byte_d  = tx_byte_q;
        wr_data_d  = wr_data_q;
        err_cnt_d  = err_cnt_q;
        reg_addr_d = reg_addr_q;
        addr_d     = addr_q;
        pref_d     = rd_en_q ? bus.i_Reg_Rd_Data : pref_q;
        if (rx_vld) begin
            case (state_q)
                IDLE: begin
                    if (cmd_bad) begin
                        tx_byte_d = ERR_BYTE;
                        tx_load_d = 1'b1;
                        err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
                    end else if (cmd_rd) begin
                        reg_addr_d = cmd_addr;
                        rd_en_d    = 1'b1;
                        addr_d     = nxt(cmd_addr);
                    end else begin
                        addr_d    = cmd_addr;
                        tx_byte_d = ACK_BYTE;
                        tx_load_d = 1'b1;
                    end
                end
                RD_TURN, RD_DATA: begin
                    tx_byte_d  = pref_q;
                    tx_load_d  = 1'b1;
                    reg_addr_d = addr_q;
                    rd_en_d    = 1'b1;
                    addr_d     = nxt(addr_q);
                end
                WR_DATA: begin
                    reg_addr_d = addr_q;
                    wr_data_d  = bus.i_RX_Byte;
                    wr_en_d    = 1'b1;
                    addr_d     = nxt(addr_q);
                end
                default: ;
            endcase
        end
    end

    assign bus.o_TX_Byte     = tx_byte_q;
    assign bus.o_TX_Load     = tx_load_q;
    assign bus.o_Reg_Addr    = reg_addr_q;
    assign bus.o_Reg_Wr_En   = wr_en_q;
    assign bus.o_Reg_Wr_Data = wr_data_q;
    assign bus.o_Reg_Rd_En   = rd_en_q;
    assign bus.o_Busy        = (state_q != IDLE);
    assign bus.o_Err_Count   = err_cnt_q;

endmodule

// File: tb/tb_spi_reg_access_ctrl.sv
// Scoreboard bench: two controllers (auto-increment on and off) share one
// byte stream; expected strobes/TX bytes are queued when stimulus is issued
// and a negedge monitor pops and compares them as the DUTs produce them.
module tb_spi_reg_access_ctrl;

    localparam int NREG = 96;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_reg_access_ctrl_if #(.ADDR_WIDTH(7)) if0 ();
    spi_reg_access_ctrl_if #(.ADDR_WIDTH(7)) if1 ();

    spi_reg_access_ctrl #(.AUTO_INC(1'b1)) dut0 (.w_SPI_Clk(clk), .i_Rst_L(rst_n), .bus(if0));
    spi_reg_access_ctrl #(.AUTO_INC(1'b0)) dut1 (.w_SPI_Clk(clk), .i_Rst_L(rst_n), .bus(if1));

    logic [7:0] bank [128];

    assign if1.i_SPI_CS_n      = if0.i_SPI_CS_n;
    assign if1.i_RX_Byte_Valid = if0.i_RX_Byte_Valid;
    assign if1.i_RX_Byte       = if0.i_RX_Byte;
    assign if0.i_Reg_Rd_Data   = bank[if0.o_Reg_Addr];
    assign if1.i_Reg_Rd_Data   = bank[if1.o_Reg_Addr];

    logic       wr_en [2], rd_en [2], tx_ld [2], busy [2];
    logic [6:0] r_addr [2];
    logic [7:0] wr_dat [2], tx_byte [2], err_cnt [2];
    assign wr_en[0] = if0.o_Reg_Wr_En;    assign wr_en[1] = if1.o_Reg_Wr_En;
    assign rd_en[0] = if0.o_Reg_Rd_En;    assign rd_en[1] = if1.o_Reg_Rd_En;
    assign tx_ld[0] = if0.o_TX_Load;      assign tx_ld[1] = if1.o_TX_Load;
    assign busy[0]  = if0.o_Busy;         assign busy[1]  = if1.o_Busy;
    assign r_addr[0] = if0.o_Reg_Addr;    assign r_addr[1] = if1.o_Reg_Addr;
    assign wr_dat[0] = if0.o_Reg_Wr_Data; assign wr_dat[1] = if1.o_Reg_Wr_Data;
    assign tx_byte[0] = if0.o_TX_Byte;    assign tx_byte[1] = if1.o_TX_Byte;
    assign err_cnt[0] = if0.o_Err_Count;  assign err_cnt[1] = if1.o_Err_Count;

    int total = 0;
    int bad   = 0;
    int err_m = 0;

    logic [14:0] wq [2][$];
    logic [6:0]  rq [2][$];
    logic [7:0]  tq [2][$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference address walk: wrap at the last register, or stay put.
    function automatic logic [6:0] step(input logic [6:0] a, input int inst);
        if (inst == 1) return a;
        return (int'(a) == NREG - 1) ? 7'd0 : a + 7'd1;
    endfunction

    // Expected consequences of a command followed by n bytes.
    task automatic push_txn(input bit rd, input logic [6:0] a, input int n,
                            input logic [3:0][7:0] d);
        logic [6:0] ad;
        if (int'(a) >= NREG) begin
            for (int i = 0; i < 2; i++) tq[i].push_back(8'hEE);
            if (err_m < 255) err_m++;
            return;
        end
        for (int i = 0; i < 2; i++) begin
            ad = a;
            if (rd) begin
                for (int k = 0; k <= n; k++) begin
                    rq[i].push_back(ad);
                    if (k < n) tq[i].push_back(bank[ad]);
                    ad = step(ad, i);
                end
            end else begin
                tq[i].push_back(8'hA5);
                for (int k = 0; k < n; k++) begin
                    wq[i].push_back({ad, d[k]});
                    ad = step(ad, i);
                end
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        if0.i_RX_Byte_Valid = 1'b1;
        if0.i_RX_Byte       = b;
        @(negedge clk);
        if0.i_RX_Byte_Valid = 1'b0;
        repeat (7) @(negedge clk);
    endtask

    task automatic end_txn(input string nm);
        if0.i_SPI_CS_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s busy inst%0d", nm, i), 32'(busy[i]), 32'd0);
            chk($sformatf("%s errcnt inst%0d", nm, i), 32'(err_cnt[i]), 32'(err_m));
        end
    endtask

    task automatic do_txn(input string nm, input bit rd, input logic [6:0] a,
                          input int n, input logic [3:0][7:0] d);
        if0.i_SPI_CS_n = 1'b0;
        @(negedge clk);
        push_txn(rd, a, n, d);
        send_byte({rd, a});
        for (int k = 0; k < n; k++) send_byte(d[k]);
        end_txn(nm);
    endtask

    // Monitor: every strobe/load must match the head of its queue.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (wr_en[i] && rd_en[i]) begin
                total++; bad++;
                $display("FAIL strobe_overlap inst%0d: wr and rd both 1, expected one", i);
            end
            if (wr_en[i]) begin
                if (wq[i].size() == 0) begin
                    total++; bad++;
                    $display("FAIL wr_unexpected inst%0d: addr %0d data %0h, expected none", i, r_addr[i], wr_dat[i]);
                end else chk($sformatf("wr inst%0d", i), 32'({r_addr[i], wr_dat[i]}), 32'(wq[i].pop_front()));
            end
            if (rd_en[i]) begin
                if (rq[i].size() == 0) begin
                    total++; bad++;
                    $display("FAIL rd_unexpected inst%0d: addr %0d, expected none", i, r_addr[i]);
                end else chk($sformatf("rd inst%0d", i), 32'(r_addr[i]), 32'(rq[i].pop_front()));
            end
            if (tx_ld[i]) begin
                if (tq[i].size() == 0) begin
                    total++; bad++;
                    $display("FAIL tx_unexpected inst%0d: byte %0h, expected none", i, tx_byte[i]);
                end else chk($sformatf("tx inst%0d", i), 32'(tx_byte[i]), 32'(tq[i].pop_front()));
            end
        end
    end

    initial begin
        logic [3:0][7:0] d;
        logic [6:0] a;
        for (int i = 0; i < 128; i++) bank[i] = 8'($urandom);
        bank[10] = 8'hC1; bank[11] = 8'hC2; bank[12] = 8'hC3;
        if0.i_SPI_CS_n = 1'b1;
        if0.i_RX_Byte_Valid = 1'b0;
        if0.i_RX_Byte = 8'h00;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst outs inst%0d", i),
                32'({wr_en[i], rd_en[i], tx_ld[i], busy[i], r_addr[i], wr_dat[i], tx_byte[i]}), 32'd0);
            chk($sformatf("rst err inst%0d", i), 32'(err_cnt[i]), 32'd0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        d = {8'h00, 8'h33, 8'h22, 8'h11};
        do_txn("wr_burst", 1'b0, 7'h05, 3, d);
        do_txn("rd_burst", 1'b1, 7'h0A, 3, 32'h0);
        do_txn("bad_addr", 1'b0, 7'h7F, 4, 32'h12345678);
        do_txn("wrap", 1'b0, 7'd95, 3, 32'h00A1B2C3);

        // Abort after one data byte, then a fresh read must start at addr 2.
        if0.i_SPI_CS_n = 1'b0;
        @(negedge clk);
        push_txn(1'b0, 7'd3, 1, 32'h5A);
        send_byte(8'h03);
        send_byte(8'h5A);
        end_txn("abort");
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("abort hold addr inst%0d", i), 32'(r_addr[i]), 32'd3);
            chk($sformatf("abort hold tx inst%0d", i), 32'(tx_byte[i]), 32'hA5);
        end
        do_txn("rd_after_abort", 1'b1, 7'h02, 2, 32'h0);

        for (int r = 0; r < 300; r++) do_txn("bad_sat", 1'b1, 7'h7F, 1, 32'h0);

        // Reset in the middle of a read burst.
        if0.i_SPI_CS_n = 1'b0;
        @(negedge clk);
        push_txn(1'b1, 7'd20, 2, 32'h0);
        send_byte(8'h94);
        send_byte(8'h00);
        send_byte(8'h00);
        rst_n = 1'b0;
        #1;
        err_m = 0;
        for (int i = 0; i < 2; i++)
            chk($sformatf("midrd rst inst%0d", i),
                32'({wr_en[i], rd_en[i], tx_ld[i], busy[i], r_addr[i], wr_dat[i], tx_byte[i], err_cnt[i]}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_txn("post_rst", 1'b0, 7'd40, 1, 32'h77);

        for (int r = 0; r < 40; r++) begin
            a = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(96, 127)) : 7'($urandom_range(0, 95));
            d = $urandom;
            do_txn("rand", 1'($urandom_range(0, 1)), a, int'($urandom_range(1, 4)), d);
        end

        repeat (4) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("wq left inst%0d", i), 32'(wq[i].size()), 32'd0);
            chk($sformatf("rq left inst%0d", i), 32'(rq[i].size()), 32'd0);
            chk($sformatf("tq left inst%0d", i), 32'(tq[i].size()), 32'd0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
